// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/forward controller: forwarding
// select codes, mult/div kinds, default latencies and the scoreboard entry.
package hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF = 2'd0;
  localparam logic [1:0] FWD_W  = 2'd1;
  localparam logic [1:0] FWD_M  = 2'd2;
  localparam logic [1:0] FWD_E  = 2'd3;

  typedef enum logic [1:0] {
    MD_NONE = 2'd0,
    MD_MULT = 2'd1,
    MD_DIV  = 2'd2,
    MD_HILO = 2'd3
  } md_kind_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int DEF_CNT_W    = 4;

  typedef struct packed {
    logic [4:0] r_new;
    logic [1:0] t_new;
    logic [4:0] r_use1;
    logic [4:0] r_use2;
    md_kind_e   md_kind;
  } stage_t;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic is_md_start(input md_kind_e k);
    return (k == MD_MULT) || (k == MD_DIV);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_cnt.sv
// HI/LO busy window: loads the unit latency when a mult/div leaves E,
// then counts down; busy while non-zero.
module md_busy_cnt
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     start_i,
  input  md_kind_e kind_i,
  output logic     busy_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = (kind_i == MD_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward controller for the 5-stage pipeline: keeps an E/M/W copy of
// each instruction's register/timing descriptors and derives stall + mux selects.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_r_use1,
  input  logic [4:0] d_r_use2,
  input  logic [1:0] d_t_use1,
  input  logic [1:0] d_t_use2,
  input  logic [4:0] d_r_new,
  input  logic [1:0] d_t_new,
  input  logic [1:0] d_md_kind,
  output logic       stall,
  output logic       md_busy,
  output logic [1:0] fwd_d_rs,
  output logic [1:0] fwd_d_rt,
  output logic [1:0] fwd_e_rs,
  output logic [1:0] fwd_e_rt,
  output logic [1:0] fwd_m_rt
);

  stage_t e_q, m_q, w_q;
  stage_t e_d, m_d, w_d;

  function automatic logic hit(input logic [4:0] r, input stage_t s);
    return (r != 5'd0) && (r == s.r_new);
  endfunction

  // The youngest matching stage decides; an older copy is never used.
  function automatic logic src_haz(input logic [4:0] r, input logic [1:0] t_use,
                                   input stage_t e, input stage_t m);
    if (hit(r, e)) return e.t_new > t_use;
    return hit(r, m) && (m.t_new > t_use);
  endfunction

  function automatic logic [1:0] sel_emw(input logic [4:0] r, input stage_t e,
                                         input stage_t m, input stage_t w);
    if (hit(r, e)) return (e.t_new == 2'd0) ? FWD_E : FWD_RF;
    if (hit(r, m)) return (m.t_new == 2'd0) ? FWD_M : FWD_RF;
    if (hit(r, w)) return FWD_W;
    return FWD_RF;
  endfunction

  function automatic logic [1:0] sel_mw(input logic [4:0] r, input stage_t m,
                                        input stage_t w);
    if (hit(r, m)) return (m.t_new == 2'd0) ? FWD_M : FWD_RF;
    if (hit(r, w)) return FWD_W;
    return FWD_RF;
  endfunction

  always_comb begin
    stall = 1'b0;
    if (src_haz(d_r_use1, d_t_use1, e_q, m_q)) stall = 1'b1;
    if (src_haz(d_r_use2, d_t_use2, e_q, m_q)) stall = 1'b1;
    if ((d_md_kind != 2'd0) && (md_busy || is_md_start(e_q.md_kind))) stall = 1'b1;
  end

  always_comb begin
    fwd_d_rs = sel_emw(d_r_use1, e_q, m_q, w_q);
    fwd_d_rt = sel_emw(d_r_use2, e_q, m_q, w_q);
    fwd_e_rs = sel_mw(e_q.r_use1, m_q, w_q);
    fwd_e_rt = sel_mw(e_q.r_use2, m_q, w_q);
    fwd_m_rt = hit(m_q.r_use2, w_q) ? FWD_W : FWD_RF;
  end

  // A stalled D slot sends an all-zero bubble into E.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.r_new   = d_r_new;
      e_d.t_new   = d_t_new;
      e_d.r_use1  = d_r_use1;
      e_d.r_use2  = d_r_use2;
      e_d.md_kind = md_kind_e'(d_md_kind);
    end
    m_d       = e_q;
    m_d.t_new = dec_sat(e_q.t_new);
    w_d       = m_q;
    w_d.t_new = dec_sat(m_q.t_new);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  md_busy_cnt #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_cnt (
    .clk     (clk),
    .reset   (reset),
    .start_i (is_md_start(e_q.md_kind)),
    .kind_i  (e_q.md_kind),
    .busy_o  (md_busy)
  );

  // W keeps its full descriptor for debug visibility; only r_new feeds logic.
  logic unused_bits;
  assign unused_bits = ^{w_q.t_new, w_q.r_use1, w_q.r_use2, w_q.md_kind,
                         m_q.r_use1, m_q.md_kind};

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/forward controller for the 5-stage MIPS pipeline.
- Takes per-instruction register and timing descriptors (r_use/t_use/r_new/t_new) decoded in D stage and keeps a scoreboard copy for E, M and W.
- Produces the pipeline stall, the forwarding-mux selects, and sequences the multi-cycle mult/div unit busy window.

Parameters:
- MULT_LAT, 5: cycles mult/multu keeps HI/LO busy after entering E.
- DIV_LAT, 10: cycles div/divu keeps HI/LO busy after entering E.
- CNT_W, 4: busy counter width; must hold max(MULT_LAT, DIV_LAT).

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high; clears all state
- d_r_use1  in  5  D-stage source reg 1 (0 = none)
- d_r_use2  in  5  D-stage source reg 2 (0 = none)
- d_t_use1  in  2  cycles after D until source 1 is consumed
- d_t_use2  in  2  cycles after D until source 2 is consumed
- d_r_new  in  5  D-stage destination reg (0 = none)
- d_t_new  in  2  cycles after entering E until result exists
- d_md_kind  in  2  0 none, 1 mult/multu, 2 div/divu, 3 mf/mt hi/lo
- stall  out  1  freeze PC and IF/ID; bubble into ID/EX
- md_busy  out  1  mult/div unit busy
- fwd_d_rs  out  2  D rs select
- fwd_d_rt  out  2  D rt select
- fwd_e_rs  out  2  E rs select
- fwd_e_rt  out  2  E rt select
- fwd_m_rt  out  2  M rt (store data) select

Behaviour:
- Select encoding: 0 RF/pipeline reg, 1 from W, 2 from M, 3 from E.
- Scoreboard: stage registers E, M, W, each holding r_new, t_new, r_use1, r_use2.
  - Every cycle M->W and E->M; t_new decrements, saturating at 0.
  - D->E loads d_* when stall=0; when stall=1, E loads a bubble (all zero).
- Stall is combinational. stall=1 if any of:
  - Source k (k = 1, 2) with d_r_use_k != 0 and d_r_use_k == E.r_new with E.t_new > d_t_use_k.
  - Same condition against M.r_new, using M.t_new.
  - d_md_kind != 0 and (md_busy or E is a mult/div start this cycle).
- D forwarding, per source:
  - E match with E.t_new == 0 -> 3.
  - Else M match with M.t_new == 0 -> 2.
  - Else W match -> 1.
  - Else 0.
  - Register 0 never matches. The youngest stage wins.
- E forwarding: E.r_use_k vs M (t_new == 0) -> 2, else W -> 1, else 0.
- M forwarding: M.r_use2 vs W -> 1, else 0.
- MD counter:
  - When an instruction with d_md_kind 1 or 2 advances into E (stall=0), the counter loads MULT_LAT or DIV_LAT on the next edge.
  - Decrements by 1 per cycle to 0.
  - md_busy = (cnt != 0).
  - A new start while busy is impossible because it is stalled.
- Reset (any time, including mid-division): all stage registers, t_new and the counter go to 0.
  - Outputs are then stall=0, md_busy=0, all fwd=0 until new instructions arrive.
- Simultaneous E and M match on the same register: E takes priority for both stall and forwarding.
- Hazard decisions ignore r_new/t_new of bubbles, which carry r_new=0.

Decomposition:
- Shared package/header: fwd select constants (FWD_RF/W/M/E), md_kind encodings, default latencies.
- One natural sub-module: md_busy_cnt (load/decrement counter, busy flag).
- Scoreboard pipeline and compare logic stay inline.

Test Plan:
- lw $1 (t_new=2) followed by addu $2,$1,$1 (t_use=1):
  - exactly 1 stall cycle.
  - then fwd_d_rs=0 and fwd_e_rs=1, from W.
- addu $3 (t_new=1) followed by beq $3 (t_use=0):
  - 1 stall.
  - then fwd_d_rs=2, from M.
- jal (r_new=31, t_new=0) followed by jr $31 (t_use=0):
  - no stall.
  - fwd_d_rs=3.
- div then mflo:
  - mflo stalls for DIV_LAT+1 cycles (E-start cycle plus 10 busy).
  - md_busy high for exactly 10 cycles.
  - mult gives MULT_LAT+1.
- lw $4 then sw $4, 0($5) (t_use2=2):
  - no stall.
  - fwd_m_rt=1 when sw reaches M.
- reset asserted on cycle 4 of a div:
  - md_busy and stall drop immediately (asynchronously).
  - a following mfhi proceeds without a stall.
